// File: rtl/car_lane_pkg.sv
// Shared types and defaults for the Frogger traffic lane.
package car_lane_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    CRASH = 1'b1
  } lane_state_t;

  localparam logic [15:0] DEFAULT_PATTERN = 16'hCCCC;

endpackage

// File: rtl/lane_tick_gen.sv
// Free-running prescaler for one lane; tick fires when the low (TICK_W-speed) bits are all ones.
module lane_tick_gen #(
  parameter int TICK_W = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] speed,
  output logic       tick,
  output logic       cnt_msb
);

  logic [TICK_W-1:0] cnt;
  logic [TICK_W-1:0] mask;

  // speed shortens the period by dropping high bits from the compare
  assign mask    = {TICK_W{1'b1}} >> speed;
  assign tick    = en && ((cnt & mask) == mask);
  assign cnt_msb = cnt[TICK_W-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/car_lane.sv
// One scrolling traffic lane with frog collision detection and a latched crash state.
// Optional build macro CAR_LANE_BLINK_EN makes the lane flash while crashed.
//
// state | meaning
// RUN   | lane scrolls on each prescaler tick, frog collisions are checked
// CRASH | image frozen at the crash instant; left only through reset
module car_lane
  import car_lane_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter int               TICK_W  = 10,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(DEFAULT_PATTERN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pause,
  input  logic                     dir,
  input  logic [1:0]               speed,
  input  logic                     frog_here,
  input  logic [$clog2(WIDTH)-1:0] frog_col,
  output logic [WIDTH-1:0]         pixels,
  output logic                     step,
  output logic                     crashed
);

  lane_state_t      state;
  logic [WIDTH-1:0] image;
  logic             run_en;
  logic             tick_en;
  logic             tick;
  logic             hit;
  logic             cnt_msb;

  assign run_en = (state == RUN) && !pause;

`ifdef CAR_LANE_BLINK_EN
  assign tick_en = run_en || (state == CRASH);
`else
  assign tick_en = run_en;
`endif

  lane_tick_gen #(
    .TICK_W(TICK_W)
  ) u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .en      (tick_en),
    .speed   (speed),
    .tick    (tick),
    .cnt_msb (cnt_msb)
  );

  // out-of-range columns are off the road and never collide
  assign hit = run_en && frog_here && (int'(frog_col) < WIDTH) && image[frog_col];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= RUN;
      image   <= PATTERN;
      step    <= 1'b0;
      crashed <= 1'b0;
    end else begin
      step <= 1'b0;
      case (state)
        RUN: begin
          if (hit) begin
            state   <= CRASH;
            crashed <= 1'b1;
          end else if (tick && run_en) begin
            image <= dir ? {image[WIDTH-2:0], image[WIDTH-1]}
                         : {image[0], image[WIDTH-1:1]};
            step  <= 1'b1;
          end
        end
        CRASH: begin
          crashed <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

`ifdef CAR_LANE_BLINK_EN
  assign pixels = ((state == CRASH) && cnt_msb) ? {WIDTH{1'b1}} : image;
`else
  logic unused_cnt_msb;
  assign unused_cnt_msb = cnt_msb;
  assign pixels         = image;
`endif

endmodule

// File: tb/tb_car_lane.sv
// Bench for car_lane: behavioural lane model checked every cycle, directed scenarios, random soak.
module tb_car_lane;

  localparam int          WIDTH  = 16;
  localparam int          TICK_W = 4;
  localparam logic [15:0] PAT    = 16'hCCCC;

  logic        clk = 1'b0;
  logic        reset;
  logic        pause;
  logic        dir;
  logic [1:0]  speed;
  logic        frog_here;
  logic [3:0]  frog_col;
  logic [15:0] pixels;
  logic        step;
  logic        crashed;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  car_lane #(
    .WIDTH  (WIDTH),
    .TICK_W (TICK_W),
    .PATTERN(PAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pause    (pause),
    .dir      (dir),
    .speed    (speed),
    .frog_here(frog_here),
    .frog_col (frog_col),
    .pixels   (pixels),
    .step     (step),
    .crashed  (crashed)
  );

  // Behavioural model: image as a number, prescaler as an integer count.
  int          m_cnt;
  int          m_img;
  bit          m_crash;
  bit          m_step;
  bit          m_valid = 1'b0;

  function automatic int rotate(input int img, input bit d);
    if (d) return ((img * 2) % 65536) + (img / 32768);
    else   return (img / 2) + ((img % 2) * 32768);
  endfunction

  function automatic int exp_pixels();
`ifdef CAR_LANE_BLINK_EN
    if (m_crash && m_cnt >= 8) return 16'hFFFF;
`endif
    return m_img;
  endfunction

  task automatic model_update();
    int  period;
    bit  running;
    bit  hitv;
    bit  tickv;
    if (!reset) begin
      m_img   = PAT;
      m_cnt   = 0;
      m_crash = 1'b0;
      m_step  = 1'b0;
      m_valid = 1'b1;
    end else if (!m_crash) begin
      period  = 16 >> speed;
      running = !pause;
      hitv    = running && frog_here && (((m_img >> frog_col) % 2) == 1);
      tickv   = running && ((m_cnt % period) == period - 1);
      m_step  = 1'b0;
      if (hitv) m_crash = 1'b1;
      else if (tickv) begin
        m_img  = rotate(m_img, dir);
        m_step = 1'b1;
      end
      if (running) m_cnt = (m_cnt + 1) % 16;
    end else begin
      m_step = 1'b0;
`ifdef CAR_LANE_BLINK_EN
      m_cnt = (m_cnt + 1) % 16;
`endif
    end
  endtask

  task automatic compare();
    if (!m_valid) return;
    n_checks++;
    if (pixels !== 16'(exp_pixels())) begin
      n_fail++;
      $display("FAIL model_pixels t=%0t got %h want %h", $time, pixels, 16'(exp_pixels()));
    end
    n_checks++;
    if (step !== m_step) begin
      n_fail++;
      $display("FAIL model_step t=%0t got %b want %b", $time, step, m_step);
    end
    n_checks++;
    if (crashed !== m_crash) begin
      n_fail++;
      $display("FAIL model_crashed t=%0t got %b want %b", $time, crashed, m_crash);
    end
  endtask

  task automatic check_lit(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Inputs are changed only just after a negedge, so the model sees the values the DUT samples.
  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset(input bit d, input logic [1:0] s);
    reset = 1'b0; pause = 1'b0; frog_here = 1'b0; frog_col = 4'd0; dir = d; speed = s;
    run(2);
    reset = 1'b1;
  endtask

  int crash_age;

  initial begin
    reset = 1'b0; pause = 1'b0; dir = 1'b0; speed = 2'd0; frog_here = 1'b0; frog_col = 4'd0;
    @(negedge clk);

    // Scenario 1: slow speed, rotate toward LSB
    do_reset(1'b0, 2'd0);
    check_lit("reset_pixels", int'(pixels), 16'hCCCC);
    check_lit("reset_crashed", int'(crashed), 0);
    run(15);
    check_lit("s1_c15_pixels", int'(pixels), 16'hCCCC);
    check_lit("s1_c15_step", int'(step), 0);
    run(1);
    check_lit("s1_c16_pixels", int'(pixels), 16'h6666);
    check_lit("s1_c16_step", int'(step), 1);
    run(1);
    check_lit("s1_c17_step", int'(step), 0);
    run(15);
    check_lit("s1_c32_pixels", int'(pixels), 16'h3333);
    run(16);
    check_lit("s1_c48_pixels", int'(pixels), 16'h9999);
    run(16);
    check_lit("s1_c64_pixels", int'(pixels), 16'hCCCC);

    // Scenario 2: fast speed, rotate toward MSB
    do_reset(1'b1, 2'd2);
    run(4);
    check_lit("s2_c4_pixels", int'(pixels), 16'h9999);
    check_lit("s2_c4_step", int'(step), 1);
    run(4);
    check_lit("s2_c8_pixels", int'(pixels), 16'h3333);
    run(4);
    check_lit("s2_c12_pixels", int'(pixels), 16'h6666);
    run(4);
    check_lit("s2_c16_pixels", int'(pixels), 16'hCCCC);

    // Scenario 3: frog on empty column, then on a car
    do_reset(1'b0, 2'd0);
    frog_here = 1'b1; frog_col = 4'd0;
    run(1);
    check_lit("s3_col0_crashed", int'(crashed), 0);
    frog_col = 4'd15;
    run(1);
    check_lit("s3_col15_crashed", int'(crashed), 1);
    check_lit("s3_col15_pixels", int'(pixels), 16'hCCCC);
    frog_here = 1'b0;
    run(100);
    check_lit("s3_hold_crashed", int'(crashed), 1);
`ifndef CAR_LANE_BLINK_EN
    check_lit("s3_hold_pixels", int'(pixels), 16'hCCCC);
`endif

    // Scenario 4: hit on the tick cycle
    do_reset(1'b0, 2'd0);
    run(15);
    frog_here = 1'b1; frog_col = 4'd15;
    run(1);
    check_lit("s4_crashed", int'(crashed), 1);
    check_lit("s4_step", int'(step), 0);
    check_lit("s4_pixels", int'(pixels), 16'hCCCC);

    // Scenario 6: reset out of CRASH
    reset = 1'b0; frog_here = 1'b0;
    run(1);
    check_lit("s6_pixels", int'(pixels), 16'hCCCC);
    check_lit("s6_crashed", int'(crashed), 0);

    // Scenario 5: pause at k=5 with frog on a car
    do_reset(1'b0, 2'd0);
    run(5);
    pause = 1'b1; frog_here = 1'b1; frog_col = 4'd14;
    run(40);
    check_lit("s5_pause_crashed", int'(crashed), 0);
    check_lit("s5_pause_pixels", int'(pixels), 16'hCCCC);
    pause = 1'b0; frog_here = 1'b0;
    run(10);
    check_lit("s5_pre_step", int'(step), 0);
    run(1);
    check_lit("s5_step", int'(step), 1);
    check_lit("s5_step_pixels", int'(pixels), 16'h6666);

    // Random soak against the model
    do_reset(1'b0, 2'd3);
    crash_age = 0;
    for (int i = 0; i < 4000; i++) begin
      crash_age = m_crash ? crash_age + 1 : 0;
      reset     = !((crash_age > 20) || ($urandom_range(0, 399) == 0));
      pause     = ($urandom_range(0, 6) == 0);
      dir       = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 40) == 0) speed = 2'($urandom_range(0, 3));
      frog_here = ($urandom_range(0, 30) == 0);
      frog_col  = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
